// File: rtl/secded_pkg.sv
// Shared types and helpers for the SECDED error monitor slice.
package secded_pkg;

    localparam int unsigned CODE_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYN_W  = 4;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        DEGRADED = 2'b01,
        FAILED   = 2'b10
    } health_t;

    // One FIFO entry: error classification plus extracted payload.
    typedef struct packed {
        logic              uncorr;
        logic              corr;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Pull the 8 data bits out of the Hamming positions (parity positions 0,1,2,4,8 skipped).
    function automatic logic [DATA_W-1:0] secded_extract_data(input logic [CODE_W-1:0] code);
        return {code[12], code[11], code[10], code[9], code[7], code[6], code[5], code[3]};
    endfunction

endpackage

// File: rtl/secded_fifo2.sv
// Two-entry registered FIFO with valid/ready on both sides.
//  clock, reset_L        : clock, async active-low reset
//  in_valid/in_ready     : write handshake; in_ready is a flop (count < 2)
//  in_data               : write payload
//  out_valid/out_ready   : read handshake; out_valid is a flop (count != 0)
//  out_data              : head entry, straight from the head register
module secded_fifo2 #(
    parameter int unsigned W = 10
) (
    input  logic         clock,
    input  logic         reset_L,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   count_q;
    logic [1:0]   count_n;
    logic [W-1:0] slot0_q;
    logic [W-1:0] slot1_q;
    logic [W-1:0] slot0_n;
    logic [W-1:0] slot1_n;
    logic         enq;
    logic         deq;

    assign enq      = in_valid & in_ready;
    assign deq      = out_valid & out_ready;
    assign out_data = slot0_q;

    // Slot 0 is always the head; slot 1 shifts forward on dequeue.
    always_comb begin
        count_n = count_q;
        slot0_n = slot0_q;
        slot1_n = slot1_q;
        case ({enq, deq})
            2'b10: begin
                if (count_q == 2'd0) slot0_n = in_data;
                else                 slot1_n = in_data;
                count_n = count_q + 2'd1;
            end
            2'b01: begin
                slot0_n = slot1_q;
                count_n = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_n = in_data;
                end else begin
                    slot0_n = slot1_q;
                    slot1_n = in_data;
                end
            end
            default: ;
        endcase
    end

    // Handshake flags follow the next count so they stay registered.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            count_q   <= 2'd0;
            slot0_q   <= '0;
            slot1_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            count_q   <= count_n;
            slot0_q   <= slot0_n;
            slot1_q   <= slot1_n;
            in_ready  <= (count_n != 2'd2);
            out_valid <= (count_n != 2'd0);
        end
    end

endmodule

// File: rtl/secded_err_monitor.sv
// SECDED decoder back end: extracts data into a 2-entry FIFO, counts errors, tracks health.
//  clock, reset_L                    : clock, async active-low reset
//  in_valid/in_ready, in_code,
//  in_syndrome, in_is1BitErr/2BitErr : decoder result stream
//  out_valid/out_ready, out_data,
//  out_corrected, out_uncorr         : extracted data stream with error flags
//  clr_counts                        : sync clear of counters, last syndrome, health
//  cnt_corr, cnt_uncorr              : saturating error counters
//  last_syndrome, health             : most recent error syndrome and health state
module secded_err_monitor
    import secded_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEGRADE_TH  = 4,
    parameter bit          DROP_UNCORR = 1'b1
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [SYN_W-1:0]  in_syndrome,
    input  logic              in_is1BitErr,
    input  logic              in_is2BitErr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corrected,
    output logic              out_uncorr,
    input  logic              clr_counts,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr,
    output logic [SYN_W-1:0]  last_syndrome,
    output logic [1:0]        health
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             accept;
    logic             is_corr;
    logic             is_uncorr;
    logic             enq;
    entry_t           in_entry;
    entry_t           out_entry;
    logic [CNT_W-1:0] cnt_corr_n;
    logic [CNT_W-1:0] cnt_uncorr_n;
    logic [SYN_W-1:0] syn_n;
    health_t          health_q;
    health_t          health_n;

    assign accept    = in_valid & in_ready;
    assign is_uncorr = in_is2BitErr;
    assign is_corr   = in_is1BitErr & ~in_is2BitErr;
    assign enq       = accept & ~(is_uncorr & DROP_UNCORR);

    assign in_entry.uncorr = is_uncorr;
    assign in_entry.corr   = is_corr;
    assign in_entry.data   = secded_extract_data(in_code);

    secded_fifo2 #(
        .W($bits(entry_t))
    ) u_fifo (
        .clock    (clock),
        .reset_L  (reset_L),
        .in_valid (enq),
        .in_ready (in_ready),
        .in_data  (in_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_entry)
    );

    assign out_data      = out_entry.data;
    assign out_corrected = out_entry.corr;
    assign out_uncorr    = out_entry.uncorr;
    assign health        = health_q;

    // Next statistics: clear first, then apply any error accepted this cycle.
    always_comb begin
        cnt_corr_n   = clr_counts ? '0 : cnt_corr;
        cnt_uncorr_n = clr_counts ? '0 : cnt_uncorr;
        syn_n        = clr_counts ? '0 : last_syndrome;
        health_n     = clr_counts ? OK : health_q;
        if (accept && is_corr) begin
            if (cnt_corr_n != CNT_MAX) cnt_corr_n = cnt_corr_n + CNT_W'(1);
            syn_n = in_syndrome;
            if (health_n == OK && 32'(cnt_corr_n) >= DEGRADE_TH) health_n = DEGRADED;
        end
        if (accept && is_uncorr) begin
            if (cnt_uncorr_n != CNT_MAX) cnt_uncorr_n = cnt_uncorr_n + CNT_W'(1);
            syn_n    = in_syndrome;
            health_n = FAILED;
        end
    end

    // Statistics and health state registers.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cnt_corr      <= '0;
            cnt_uncorr    <= '0;
            last_syndrome <= '0;
            health_q      <= OK;
        end else begin
            cnt_corr      <= cnt_corr_n;
            cnt_uncorr    <= cnt_uncorr_n;
            last_syndrome <= syn_n;
            health_q      <= health_n;
        end
    end

endmodule

// File: tb/tb_secded_err_monitor.sv
// Scoreboard bench for secded_err_monitor (default parameters).
module tb_secded_err_monitor;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned TH    = 4;

    logic             clock;
    logic             reset_L;
    logic             in_valid;
    logic             in_ready;
    logic [12:0]      in_code;
    logic [3:0]       in_syndrome;
    logic             in_is1BitErr;
    logic             in_is2BitErr;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_corrected;
    logic             out_uncorr;
    logic             clr_counts;
    logic [CNT_W-1:0] cnt_corr;
    logic [CNT_W-1:0] cnt_uncorr;
    logic [3:0]       last_syndrome;
    logic [1:0]       health;

    secded_err_monitor #(
        .CNT_W      (CNT_W),
        .DEGRADE_TH (TH),
        .DROP_UNCORR(1'b1)
    ) dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_code      (in_code),
        .in_syndrome  (in_syndrome),
        .in_is1BitErr (in_is1BitErr),
        .in_is2BitErr (in_is2BitErr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_corrected(out_corrected),
        .out_uncorr   (out_uncorr),
        .clr_counts   (clr_counts),
        .cnt_corr     (cnt_corr),
        .cnt_uncorr   (cnt_uncorr),
        .last_syndrome(last_syndrome),
        .health       (health)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] sb[$];
    logic [7:0] m_corr;
    logic [7:0] m_uncorr;
    logic [3:0] m_syn;
    logic [1:0] m_health;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Place data bits at Hamming positions 3,5,6,7,9,10,11,12; arbitrary check bits elsewhere.
    function automatic logic [12:0] mk_code(input logic [7:0] d, input logic [4:0] chk);
        logic [12:0] c;
        c[0]  = chk[0]; c[1]  = chk[1]; c[2] = chk[2]; c[4] = chk[3]; c[8] = chk[4];
        c[3]  = d[0];   c[5]  = d[1];   c[6] = d[2];   c[7] = d[3];
        c[9]  = d[4];   c[10] = d[5];   c[11] = d[6];  c[12] = d[7];
        return c;
    endfunction

    task automatic model_clear();
        m_corr = 8'h00; m_uncorr = 8'h00; m_syn = 4'h0; m_health = 2'b00;
    endtask

    task automatic check_stats(input string tag);
        check_eq({tag, ".cnt_corr"},      32'(cnt_corr),      32'(m_corr));
        check_eq({tag, ".cnt_uncorr"},    32'(cnt_uncorr),    32'(m_uncorr));
        check_eq({tag, ".last_syndrome"}, 32'(last_syndrome), 32'(m_syn));
        check_eq({tag, ".health"},        32'(health),        32'(m_health));
    endtask

    // Drive one word; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic send(input logic [7:0] d, input logic e1, input logic e2,
                        input logic [3:0] syn, input logic clr);
        bit acc = 1'b0;
        in_code      = mk_code(d, 5'($urandom));
        in_syndrome  = syn;
        in_is1BitErr = e1;
        in_is2BitErr = e2;
        clr_counts   = clr;
        in_valid     = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            check_eq("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            if (clr) model_clear();
            if (e1 && !e2) begin
                if (m_corr != 8'hFF) m_corr = m_corr + 8'd1;
                m_syn = syn;
                if (m_health == 2'b00 && 32'(m_corr) >= TH) m_health = 2'b01;
            end
            if (e2) begin
                if (m_uncorr != 8'hFF) m_uncorr = m_uncorr + 8'd1;
                m_syn    = syn;
                m_health = 2'b10;
            end
            if (!e2) sb.push_back({1'b0, e1, d});
        end
        @(posedge clock); #1;
        in_valid = 1'b0; clr_counts = 1'b0; in_is1BitErr = 1'b0; in_is2BitErr = 1'b0;
    endtask

    task automatic do_clear();
        clr_counts = 1'b1;
        @(posedge clock); #1;
        clr_counts = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Output side of the scoreboard: compare every dequeued entry.
    always @(negedge clock) begin
        if (reset_L && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("out_valid_unexpected", 32'(out_valid), 32'd0);
            end else begin
                logic [9:0] exp;
                exp = sb.pop_front();
                check_eq("out_entry", 32'({out_uncorr, out_corrected, out_data}), 32'(exp));
            end
        end
    end

    initial begin
        reset_L = 1'b0; in_valid = 1'b0; in_code = '0; in_syndrome = '0;
        in_is1BitErr = 1'b0; in_is2BitErr = 1'b0; out_ready = 1'b0; clr_counts = 1'b0;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.in_ready",  32'(in_ready),  32'd1);
        check_eq("rst.out_data",  32'({out_uncorr, out_corrected, out_data}), 32'd0);
        check_stats("rst");
        @(negedge clock); reset_L = 1'b1;
        @(posedge clock); #1;

        // 1: clean word, one-cycle latency
        send(8'hA5, 1'b0, 1'b0, 4'h0, 1'b0);
        check_eq("t1.out_valid", 32'(out_valid), 32'd1);
        check_eq("t1.out_data",  32'(out_data),  32'hA5);
        check_stats("t1");
        drain();

        // 2: four corrected errors reach the degrade threshold
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom), 1'b1, 1'b0, 4'h6, 1'b0);
            check_stats("t2");
        end
        drain();

        // 3: uncorrectable words are dropped and force FAILED; clear restores OK
        send(8'h3C, 1'b0, 1'b1, 4'h9, 1'b0);
        check_eq("t3.out_valid", 32'(out_valid), 32'd0);
        check_stats("t3a");
        send(8'hC3, 1'b1, 1'b1, 4'h3, 1'b0);
        check_eq("t3.out_valid2", 32'(out_valid), 32'd0);
        check_stats("t3b");
        do_clear();
        check_stats("t3c");

        // 4: backpressure, fill, then drain in order
        out_ready = 1'b0;
        send(8'h11, 1'b0, 1'b0, 4'h0, 1'b0);
        send(8'h22, 1'b1, 1'b0, 4'h2, 1'b0);
        check_eq("t4.in_ready_full", 32'(in_ready), 32'd0);
        check_eq("t4.head",          32'(out_data), 32'h11);
        fork
            send(8'h33, 1'b0, 1'b0, 4'h0, 1'b0);
            begin
                repeat (3) @(negedge clock);
                check_eq("t4.in_ready_held", 32'(in_ready), 32'd0);
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        send(8'h44, 1'b0, 1'b0, 4'h0, 1'b0);
        send(8'h55, 1'b1, 1'b0, 4'h1, 1'b0);
        check_stats("t4");
        drain();

        // 5: counter saturation, then clear with a concurrent error
        do_clear();
        for (int i = 0; i < 260; i++) send(8'($urandom), 1'b1, 1'b0, 4'($urandom), 1'b0);
        check_stats("t5a");
        send(8'h5A, 1'b1, 1'b0, 4'h5, 1'b1);
        check_stats("t5b");
        drain();

        // 6: asynchronous reset with a full FIFO
        out_ready = 1'b0;
        send(8'h77, 1'b1, 1'b0, 4'hA, 1'b0);
        send(8'h88, 1'b0, 1'b1, 4'hB, 1'b0);
        send(8'h99, 1'b0, 1'b0, 4'h0, 1'b0);
        check_eq("t6.in_ready_full", 32'(in_ready), 32'd0);
        @(negedge clock); #2;
        reset_L = 1'b0;
        #1;
        sb.delete();
        model_clear();
        check_eq("t6.out_valid", 32'(out_valid), 32'd0);
        check_eq("t6.in_ready",  32'(in_ready),  32'd1);
        check_stats("t6");
        @(negedge clock); reset_L = 1'b1;
        @(posedge clock); #1;
        send(8'hE7, 1'b0, 1'b0, 4'h0, 1'b0);
        check_eq("t6.after_out_data", 32'(out_data), 32'hE7);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
